// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared types, constants and default init table for the OLED sequencer
// Purpose: entry type codes, the 10-bit seq_entry_t ROM word, the FSM state
//          encoding, the idle value of DATA and the default SSD1331 init table.
// Ports:   none (package).
package oled_pkg;

    typedef enum logic [1:0] {
        ENT_CMD   = 2'b00,
        ENT_DATA  = 2'b01,
        ENT_DELAY = 2'b10,
        ENT_END   = 2'b11
    } entry_type_e;

    // kind occupies DATA[9:8] so a write entry maps straight onto the SPI word
    typedef struct packed {
        entry_type_e kind;
        logic [7:0]  arg;
    } seq_entry_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_FETCH,
        S_WRITE,
        S_GAP,
        S_DELAY,
        S_FIN,
        S_ERROR
    } seq_state_e;

    localparam logic [9:0] DATA_IDLE     = 10'h300;
    localparam int         DEFAULT_DEPTH = 32;

    typedef seq_entry_t [DEFAULT_DEPTH-1:0] seq_table_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // SSD1331 power-up list; parameter bytes are sent in command mode as the panel expects
    function automatic seq_table_t default_table();
        seq_table_t t;
        for (int i = 0; i < DEFAULT_DEPTH; i++) begin
            t[i] = '{kind: ENT_END, arg: 8'h00};
        end
        t[0]  = '{kind: ENT_CMD,   arg: 8'hAE};
        t[1]  = '{kind: ENT_CMD,   arg: 8'h81};
        t[2]  = '{kind: ENT_CMD,   arg: 8'hFF};
        t[3]  = '{kind: ENT_CMD,   arg: 8'h82};
        t[4]  = '{kind: ENT_CMD,   arg: 8'hFF};
        t[5]  = '{kind: ENT_CMD,   arg: 8'h83};
        t[6]  = '{kind: ENT_CMD,   arg: 8'hFF};
        t[7]  = '{kind: ENT_CMD,   arg: 8'h87};
        t[8]  = '{kind: ENT_CMD,   arg: 8'h06};
        t[9]  = '{kind: ENT_CMD,   arg: 8'h8A};
        t[10] = '{kind: ENT_CMD,   arg: 8'h64};
        t[11] = '{kind: ENT_CMD,   arg: 8'h8B};
        t[12] = '{kind: ENT_CMD,   arg: 8'h78};
        t[13] = '{kind: ENT_CMD,   arg: 8'h8C};
        t[14] = '{kind: ENT_CMD,   arg: 8'h64};
        t[15] = '{kind: ENT_CMD,   arg: 8'hA0};
        t[16] = '{kind: ENT_CMD,   arg: 8'h72};
        t[17] = '{kind: ENT_CMD,   arg: 8'hA1};
        t[18] = '{kind: ENT_CMD,   arg: 8'h00};
        t[19] = '{kind: ENT_CMD,   arg: 8'hA2};
        t[20] = '{kind: ENT_CMD,   arg: 8'h00};
        t[21] = '{kind: ENT_CMD,   arg: 8'hA4};
        t[22] = '{kind: ENT_CMD,   arg: 8'hAF};
        t[23] = '{kind: ENT_DELAY, arg: 8'd100};
        t[24] = '{kind: ENT_END,   arg: 8'h00};
        return t;
    endfunction

endpackage

// File: rtl/oled_seq_rom.sv
// rtl/oled_seq_rom.sv - registered sequence ROM, 1-cycle read latency
// Purpose: returns TABLE[addr_i] one clock after the address is presented.
// Ports:   clk_i, rst_i (async, active high), addr_i (entry index),
//          entry_o (registered seq_entry_t).
module oled_seq_rom
    import oled_pkg::*;
#(
    parameter int                         DEPTH = 32,
    parameter int                         IDX_W = 5,
    parameter seq_entry_t [DEPTH-1:0]     TABLE = default_table()
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] addr_i,
    output seq_entry_t       entry_o
);

    seq_entry_t entry_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= '{kind: ENT_END, arg: 8'h00};
        end else begin
            entry_q <= TABLE[addr_i];
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/oled_init_sequencer.sv
// rtl/oled_init_sequencer.sv - table-driven OLED power-up sequencer
// Purpose: on a START rising edge, holds the panel in hard reset, waits, then
//          plays SEQ_TABLE entries (command/data writes, delays, end) into the
//          SPI byte writer. Optional WRITE_DONE watchdog: OLED_SEQ_TIMEOUT_EN.
// Ports:   CLK, RST (async, active high), START (level, edge-triggered),
//          DONE/BUSY/ERR status, WRITE_START/WRITE_DONE/DATA SPI handshake,
//          RST_OLED (panel reset, active low), STEP_IDX (current ROM index).
module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int                         SEQ_LEN         = 24,
    parameter int                         SEQ_DEPTH       = 32,
    parameter int                         RST_LOW_CYCLES  = 1000000,
    parameter int                         RST_WAIT_CYCLES = 1000000,
    parameter int                         DELAY_UNIT      = 1000,
    parameter int                         TIMEOUT_CYCLES  = 65535,
    parameter seq_entry_t [SEQ_DEPTH-1:0] SEQ_TABLE       = default_table()
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    output logic                         DONE,
    output logic                         BUSY,
    output logic                         ERR,
    output logic                         WRITE_START,
    input  logic                         WRITE_DONE,
    output logic [9:0]                   DATA,
    output logic                         RST_OLED,
    output logic [$clog2(SEQ_DEPTH)-1:0] STEP_IDX
);

    localparam int IDX_W   = $clog2(SEQ_DEPTH);
    localparam int CNT_MAX = max_int(max_int(RST_LOW_CYCLES, RST_WAIT_CYCLES),
                                     max_int(255 * DELAY_UNIT, TIMEOUT_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e       state_q, state_d, adv_state;
    logic [IDX_W-1:0] step_q, step_d, adv_step;
    logic [CNT_W-1:0] cnt_q, cnt_d, delay_last;
    logic             start_cur_q, start_prev_q, start_edge, last_step;
    seq_entry_t       rom_entry;

    // Addressed with the next index so the entry is already valid during FETCH
    oled_seq_rom #(
        .DEPTH (SEQ_DEPTH),
        .IDX_W (IDX_W),
        .TABLE (SEQ_TABLE)
    ) u_rom (
        .clk_i   (CLK),
        .rst_i   (RST),
        .addr_i  (step_d),
        .entry_o (rom_entry)
    );

    assign start_edge = start_cur_q & ~start_prev_q;
    assign last_step  = (step_q == IDX_W'(SEQ_LEN - 1));
    assign delay_last = CNT_W'(rom_entry.arg) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

    // Shared step advance for GAP, DELAY and zero-length DELAY; no wrap past the last entry
    assign adv_state = last_step ? S_FIN : S_FETCH;
    assign adv_step  = last_step ? step_q : step_q + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            cnt_q        <= '0;
            start_cur_q  <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            start_cur_q  <= START;
            start_prev_q <= start_cur_q;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE, S_FIN, S_ERROR: begin
                if (start_edge) begin
                    state_d = S_RST_LOW;
                    step_d  = '0;
                end
            end
            S_RST_LOW: begin
                if (cnt_q == CNT_W'(RST_LOW_CYCLES - 1)) state_d = S_RST_WAIT;
            end
            S_RST_WAIT: begin
                if (cnt_q == CNT_W'(RST_WAIT_CYCLES - 1)) state_d = S_FETCH;
            end
            S_FETCH: begin
                case (rom_entry.kind)
                    ENT_CMD, ENT_DATA: state_d = S_WRITE;
                    ENT_DELAY: begin
                        if (rom_entry.arg == 8'd0) begin
                            state_d = adv_state;
                            step_d  = adv_step;
                        end else begin
                            state_d = S_DELAY;
                        end
                    end
                    default: state_d = S_FIN;
                endcase
            end
            S_WRITE: begin
                if (WRITE_DONE) begin
                    state_d = S_GAP;
                end
`ifdef OLED_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end
`endif
            end
            S_GAP: begin
                state_d = adv_state;
                step_d  = adv_step;
            end
            S_DELAY: begin
                if (cnt_q == delay_last) begin
                    state_d = adv_state;
                    step_d  = adv_step;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Cycle counter restarts on every state change and saturates otherwise
        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Outputs decode state_q directly so RST clears them without waiting for a clock
    assign WRITE_START = (state_q == S_WRITE);
    assign DATA        = (state_q == S_WRITE) ? {rom_entry.kind, rom_entry.arg} : DATA_IDLE;
    assign RST_OLED    = !(state_q inside {S_IDLE, S_RST_LOW});
    assign BUSY        = !(state_q inside {S_IDLE, S_FIN, S_ERROR});
    assign DONE        = (state_q == S_FIN);
    assign STEP_IDX    = step_q;
`ifdef OLED_SEQ_TIMEOUT_EN
    assign ERR         = (state_q == S_ERROR);
`else
    assign ERR         = 1'b0;
`endif

endmodule
